// File: rtl/tablero_colores.sv
// 4x4 colour board behind the VGA display: a zero-latency read port for the
// renderer plus debounced push-buttons driving a cursor, colour cycling and clear.
module tablero_colores #(
    parameter int            AW          = 4,
    parameter int            DW          = 3,
    parameter int            DEB_CYCLES  = 250000,
    parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_next,
    input  logic          btn_color,
    input  logic          btn_clear,
    input  logic [AW-1:0] posicion,
    output logic [DW-1:0] dirColor,
    output logic [AW-1:0] cursor,
    output logic          busy,
    output logic          wr_done,
    output logic [1:0]    state_dbg
);

    localparam int CELLS = 1 << AW;
    localparam int CW    = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // Button lanes: bit 0 = next, bit 1 = color, bit 2 = clear.
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [2:0]    level_d;
    logic [CW-1:0] deb_cnt [3];
    logic [2:0]    btn_ev;

    state_t        state;
    logic [AW-1:0] clear_addr;
    logic [DW-1:0] cells [CELLS];

    assign btn_raw = {btn_clear, btn_color, btn_next};

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any bounce back to the old level restarts the wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_MAX) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_ev = level & ~level_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cursor     <= '0;
            busy       <= 1'b0;
            wr_done    <= 1'b0;
            clear_addr <= '0;
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= CLEAR_COLOR;
            end
        end else begin
            wr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only one event is honoured per cycle; the rest are dropped.
                    if (btn_ev[2]) begin
                        state      <= S_CLEAR;
                        clear_addr <= '0;
                        busy       <= 1'b1;
                    end else if (btn_ev[1]) begin
                        state <= S_WRITE;
                        busy  <= 1'b1;
                    end else if (btn_ev[0]) begin
                        cursor <= cursor + 1'b1;
                    end
                end
                S_WRITE: begin
                    cells[cursor] <= cells[cursor] + 1'b1;
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    wr_done       <= 1'b1;
                end
                S_CLEAR: begin
                    cells[clear_addr] <= CLEAR_COLOR;
                    clear_addr        <= clear_addr + 1'b1;
                    if (clear_addr == '1) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        wr_done <= 1'b1;
                        cursor  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dirColor  = cells[posicion];
    assign state_dbg = state;

endmodule

// File: tb/tb_tablero_colores.sv
// Bench for tablero_colores: vector table for cursor/colour presses, a wr_done
// scoreboard, and hand-written clear, simultaneous-event and mid-clear reset sequences.
module tb_tablero_colores;

    localparam int AW    = 4;
    localparam int DW    = 3;
    localparam int DEB   = 4;
    localparam int CELLS = 16;
    localparam logic [DW-1:0] CLR = 3'b000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_next = 1'b0;
    logic          btn_color = 1'b0;
    logic          btn_clear = 1'b0;
    logic [AW-1:0] posicion = '0;
    logic [DW-1:0] dirColor;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          wr_done;
    logic [1:0]    state_dbg;

    tablero_colores #(
        .AW(AW), .DW(DW), .DEB_CYCLES(DEB), .CLEAR_COLOR(CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_next(btn_next), .btn_color(btn_color), .btn_clear(btn_clear),
        .posicion(posicion), .dirColor(dirColor),
        .cursor(cursor), .busy(busy), .wr_done(wr_done), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    int            wr_count = 0;
    int            busy_cycles = 0;
    int            busy_run = 0;
    int            last_run = 0;

    logic [DW-1:0] m_cells [CELLS];
    logic [AW-1:0] m_cursor;

    typedef struct {
        int            btn;       // 0 = next, 1 = color
        logic [AW-1:0] pos;
        logic [AW-1:0] exp_cursor;
        logic [DW-1:0] exp_color;
    } vec_t;
    vec_t vecs [25];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // wr_done monitor: every completion pops one expected colour for the watched cell.
    always @(negedge clk) begin
        if (busy) begin
            busy_cycles++;
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (wr_done) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("wr_done_unexpected", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("wr_done_color", dirColor, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_next = v;
            1: btn_color = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic press(input int which);
        @(posedge clk); #1;
        set_btn(which, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        set_btn(which, 1'b0);
        repeat (DEB + 8) @(posedge clk);
        #1;
    endtask

    task automatic press_next();
        press(0);
        m_cursor = m_cursor + 1'b1;
    endtask

    task automatic press_color();
        posicion = m_cursor;
        m_cells[m_cursor] = m_cells[m_cursor] + 1'b1;
        exp_q.push_back(m_cells[m_cursor]);
        press(1);
    endtask

    task automatic goto_cell(input logic [AW-1:0] t);
        for (int n = 0; n < CELLS && m_cursor != t; n++) press_next();
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) m_cells[i] = CLR;
        m_cursor = '0;
    endtask

    task automatic check_board(input string name);
        for (int i = 0; i < CELLS; i++) begin
            @(posedge clk); #2;
            posicion = AW'(i);
            #1;
            check(name, dirColor, m_cells[i]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    int lat;
    int w0;
    int b0;
    int got;

    initial begin
        for (int i = 0; i < CELLS; i++) m_cells[i] = CLR;
        m_cursor = '0;
        for (int i = 0; i < 9; i++)
            vecs[i] = '{1, 4'd1, 4'd1, DW'((i + 1) % 8)};
        for (int i = 0; i < 16; i++)
            vecs[9 + i] = '{0, 4'd1, AW'((2 + i) % 16), 3'd1};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cursor", cursor, 0);
        check("reset_busy", busy, 0);
        check("reset_wr_done", wr_done, 0);
        check("reset_state", state_dbg, 0);
        check_board("reset_board");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Long btn_next press: one event, latency inside the debounce window
        b0 = busy_cycles;
        lat = -1;
        btn_next = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 10) btn_next = 1'b0;
            if (lat < 0 && cursor != 0) lat = n;
        end
        if (lat < DEB + 1 || lat > DEB + 4)
            $display("next event latency %0d cycles", lat);
        check("next_latency_window", (lat >= DEB + 1 && lat <= DEB + 4) ? 1 : 0, 1);
        check("next_single_event", cursor, 1);
        check("next_no_busy", busy_cycles - b0, 0);
        m_cursor = 4'd1;
        check_board("after_next_board");

        // Glitches shorter than the debounce window
        for (int g = 0; g < 5; g++) begin
            @(posedge clk); #1;
            btn_next = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            btn_next = 1'b0;
            repeat (1) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
        check("glitch_cursor", cursor, 1);

        // Vector table: nine colour presses on cell 1, then sixteen cursor steps
        w0 = wr_count;
        b0 = busy_cycles;
        for (int v = 0; v < 25; v++) begin
            posicion = vecs[v].pos;
            if (vecs[v].btn == 1) begin
                exp_q.push_back(vecs[v].exp_color);
                press(1);
            end else begin
                press(0);
            end
            @(negedge clk);
            check("vec_cursor", cursor, vecs[v].exp_cursor);
            check("vec_color", dirColor, vecs[v].exp_color);
            @(posedge clk); #1;
        end
        check("vec_wr_done_count", wr_count - w0, 9);
        check("vec_busy_cycles", busy_cycles - b0, 9);
        check("vec_queue_empty", exp_q.size(), 0);
        m_cells[1] = 3'd1;
        m_cursor = 4'd1;

        // Paint cells 5, 15 and 0
        goto_cell(4'd5);
        press_color();
        goto_cell(4'd15);
        press_color();
        goto_cell(4'd0);
        press_color();
        check_board("setup_board");
        check("setup_cursor", cursor, 0);

        // Clear with a colour press arriving mid-clear (must be dropped)
        w0 = wr_count;
        posicion = 4'd5;
        exp_q.push_back(CLR);
        @(posedge clk); #1;
        btn_clear = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        btn_color = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn_clear = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        btn_color = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("clear_busy_len", last_run, 16);
        check("clear_wr_done_count", wr_count - w0, 1);
        check("clear_cursor", cursor, 0);
        check("clear_queue_empty", exp_q.size(), 0);
        model_clear();
        check_board("clear_board");

        // Clear and colour events in the same cycle
        press_color();
        w0 = wr_count;
        posicion = 4'd0;
        exp_q.push_back(CLR);
        @(posedge clk); #1;
        btn_clear = 1'b1;
        btn_color = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        btn_clear = 1'b0;
        btn_color = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("simul_busy_len", last_run, 16);
        check("simul_wr_done_count", wr_count - w0, 1);
        model_clear();
        check_board("simul_board");

        // Reset in the middle of a clear
        goto_cell(4'd9);
        press_color();
        @(posedge clk); #1;
        btn_clear = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        btn_clear = 1'b0;
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            @(posedge clk); #1;
            if (busy_run >= 7) got = 1;
        end
        check("midclear_reached", got, 1);
        rst = 1'b0;
        #1;
        check("midclear_rst_busy", busy, 0);
        check("midclear_rst_cursor", cursor, 0);
        check("midclear_rst_wr_done", wr_done, 0);
        check("midclear_rst_state", state_dbg, 0);
        posicion = 4'd9;
        #1;
        check("midclear_rst_cell9", dirColor, CLR);
        model_clear();
        check_board("midclear_board");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        w0 = wr_count;
        press_color();
        check("post_reset_wr_done", wr_count - w0, 1);
        check_board("post_reset_board");
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tablero_colores.md
Name: tablero_colores

Overview:
- Owns the 4x4 grid of 3-bit colour codes that the VGA display block renders.
- The display side presents a cell index on `posicion` and reads back the colour on `dirColor` with zero latency.
- The user side uses three push-buttons: move a cursor, cycle the colour of the cursor cell, and clear the whole board.
- Button inputs are synchronised and debounced, and writes are sequenced by a small FSM.

Parameters:
- AW, 4: cell index width; the board holds 2^AW = 16 cells.
- DW, 3: colour code width, RGB 1-bit each, bit2=R, bit1=G, bit0=B.
- DEB_CYCLES, 250000: number of consecutive stable clk cycles required to accept a button level.
- CLEAR_COLOR, 3'b000: value written on reset and on clear.

Ports:
- clk, in, 1: system clock; same clock that feeds the display block.
- rst, in, 1: reset, asynchronous, active-low.
- btn_next, in, 1: raw button; advance the cursor.
- btn_color, in, 1: raw button; cycle the colour of the cursor cell.
- btn_clear, in, 1: raw button; clear all cells.
- posicion, in, AW: cell index requested by the display.
- dirColor, out, DW: colour code of cell `posicion`.
- cursor, out, AW: current cursor cell index.
- busy, out, 1: high while a write or clear sequence is in progress.
- wr_done, out, 1: one-cycle pulse when a write or clear completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - all 16 cells = CLEAR_COLOR; cursor=0; busy=0; wr_done=0; FSM=IDLE.
  - synchronisers, debounce counters and debounced levels = 0.
- Button front end, per button:
  - 2-flop synchroniser, then a debounce counter.
  - The counter resets whenever the synchronised input differs from the debounced level.
  - When the counter reaches DEB_CYCLES-1, the debounced level takes the input value.
  - A rising edge of the debounced level produces a 1-cycle event. Falling edges produce no event.
  - Latency from a stable raw press to the event: 2 + DEB_CYCLES cycles (±1). The bench checks the window, not the exact cycle.
- Read port:
  - dirColor = cells[posicion], purely combinational, zero latency.
  - A write becomes visible on dirColor the cycle after the write edge.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE:
  - Event priority: clear > color > next. Lower-priority events in the same cycle are discarded.
  - clear event -> CLEAR; clear_addr=0; busy=1.
  - color event -> WRITE; busy=1.
  - next event -> cursor = cursor+1 mod 16 (15 wraps to 0); stay in IDLE; busy stays 0; no wr_done.
- WRITE (exactly 1 cycle):
  - cells[cursor] = cells[cursor]+1 mod 8 (7 wraps to 0).
  - Next state IDLE; wr_done=1 for that one cycle; busy=0.
- CLEAR (exactly 16 cycles):
  - Each cycle: cells[clear_addr] = CLEAR_COLOR, then clear_addr+1.
  - After writing address 15 -> IDLE; wr_done pulses 1 cycle; busy=0; cursor = 0.
- busy is asserted from the cycle after the accepted event until the FSM returns to IDLE.
- Events arriving while busy=1 are dropped, not queued.
- The display may read any cell during CLEAR. Already-cleared cells return CLEAR_COLOR and the rest return old values; there is no stall of dirColor.
- Reset asserted mid-CLEAR or mid-WRITE: immediate full reset state; no partial-state residue.
- All state changes occur on the rising edge of clk. Outputs are registered except dirColor.

Test Plan:
- Sim with DEB_CYCLES=4. Release rst, hold btn_next high 10 cycles -> exactly one event; cursor 0->1; busy stays 0; dirColor for all posicion = 0.
- Press btn_color 9 times with cursor=1 -> cell1 goes 1,2,…,7,0,1; each press gives one wr_done pulse. With posicion=1, dirColor=3'b001 at the end; with posicion=0, dirColor=0.
- Toggle btn_next with 2-cycle glitches (shorter than DEB_CYCLES) -> no event; cursor unchanged. Press btn_next 16 clean times -> cursor wraps 15->0.
- Set cells 0,5,15 to nonzero, then press btn_clear:
  - busy high for exactly 16 cycles; one wr_done pulse; then all cells 0 and cursor=0.
  - btn_color pressed during the clear is ignored: cell unchanged afterwards.
- Simultaneous clear and color events in the same cycle -> CLEAR taken; no colour increment occurs.
- Assert rst low at cycle 7 of a CLEAR -> cells=0, cursor=0, busy=0 asynchronously. After release, the block accepts a new color event normally.
